weight_dma_packer: RTL

Upstream feeder for the weight buffer stage. It takes the 32-bit word stream from the AXI read DMA and packs consecutive words into full weight lines of N×MAC_NUM×WEIGHT_BITS bits. It writes those lines into one of two ping-pong weight SRAM banks. The block issues the DMA request itself, tracks which bank is full, and hands full banks to the weight consumer through a full/release handshake.

---
 rtl/weight_dma_packer_pkg.sv | 20 ++
 rtl/weight_dma_packer_line_assembler.sv | 57 +++++
 rtl/weight_dma_packer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/weight_dma_packer_pkg.sv
// Weight-geometry constants and FSM state encoding shared by the weight DMA
// packer and the weight buffer/consumer stage.
package weight_dma_packer_pkg;

  localparam int WEIGHT_BITS  = 8;
  localparam int N            = 16;
  localparam int MAC_NUM      = 9;
  localparam int AXI_WIDTH_DA = 32;
  localparam int LINE_BITS    = N * MAC_NUM * WEIGHT_BITS;
  localparam int WPL          = LINE_BITS / AXI_WIDTH_DA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BANK,
    ST_ISSUE,
    ST_FILL,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/weight_dma_packer_line_assembler.sv
// Packs DMA words into one weight line (word k at bits [32k+31:32k]) and
// pulses line_valid the cycle after the last slot of a line is written.
module weight_line_assembler #(
  parameter int AXI_WIDTH_DA = 32,
  parameter int LINE_BITS    = 1152,
  parameter int WPL          = 36
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    word_wr,
  input  logic [AXI_WIDTH_DA-1:0] word,
  output logic [LINE_BITS-1:0]    line,
  output logic                    line_valid
);

  localparam int CW = (WPL > 1) ? $clog2(WPL) : 1;

  logic [CW-1:0]        word_cnt_q, word_cnt_d;
  logic [LINE_BITS-1:0] line_q, line_d;
  logic                 line_valid_q, line_valid_d;

  // The slot written while line_valid is high belongs to the next line, so the
  // completed line stays readable for exactly the write cycle.
  always_comb begin
    word_cnt_d   = word_cnt_q;
    line_d       = line_q;
    line_valid_d = 1'b0;
    if (clr) begin
      word_cnt_d = '0;
    end else if (word_wr) begin
      line_d[word_cnt_q*AXI_WIDTH_DA +: AXI_WIDTH_DA] = word;
      if (word_cnt_q == CW'(WPL - 1)) begin
        word_cnt_d   = '0;
        line_valid_d = 1'b1;
      end else begin
        word_cnt_d = word_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt_q   <= '0;
      line_q       <= '0;
      line_valid_q <= 1'b0;
    end else begin
      word_cnt_q   <= word_cnt_d;
      line_q       <= line_d;
      line_valid_q <= line_valid_d;
    end
  end

  assign line       = line_q;
  assign line_valid = line_valid_q;

endmodule

// File: rtl/weight_dma_packer.sv
// Weight DMA packer: launches the tile DMA, packs the word stream into weight
// lines and fills ping-pong SRAM banks handed to the consumer via bank_full.
module weight_dma_packer #(
  parameter int WEIGHT_BITS  = weight_dma_packer_pkg::WEIGHT_BITS,
  parameter int N            = weight_dma_packer_pkg::N,
  parameter int MAC_NUM      = weight_dma_packer_pkg::MAC_NUM,
  parameter int AXI_WIDTH_DA = weight_dma_packer_pkg::AXI_WIDTH_DA,
  parameter int AXI_WIDTH_AD = 32,
  parameter int BITS_TRANS   = 18,
  parameter int SRAM_ADDRESS = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                tile_start,
  input  logic [AXI_WIDTH_AD-1:0]             tile_addr,
  input  logic [SRAM_ADDRESS:0]               tile_lines,
  output logic                                busy,
  output logic                                dma_start,
  output logic [AXI_WIDTH_AD-1:0]             dma_addr,
  output logic [BITS_TRANS-1:0]               dma_num_trans,
  input  logic [AXI_WIDTH_DA-1:0]             dma_data,
  input  logic                                dma_vld,
  input  logic                                dma_done,
  output logic [1:0]                          sram_we,
  output logic [SRAM_ADDRESS-1:0]             sram_addr,
  output logic [N*MAC_NUM*WEIGHT_BITS-1:0]    sram_wdata,
  output logic [1:0]                          bank_full,
  input  logic [1:0]                          bank_release,
  output logic                                load_done,
  output logic                                err
);

  import weight_dma_packer_pkg::*;

  localparam int LINE_BITS = N * MAC_NUM * WEIGHT_BITS;
  localparam int WPL       = LINE_BITS / AXI_WIDTH_DA;
  localparam int LW        = SRAM_ADDRESS + 1;

  if (LINE_BITS % AXI_WIDTH_DA != 0) begin : g_line_check
    $error("LINE_BITS must be a multiple of AXI_WIDTH_DA");
  end

  state_e                  state_q, state_d;
  logic [AXI_WIDTH_AD-1:0] addr_q, addr_d;
  logic [LW-1:0]           lines_q, lines_d;
  logic [LW-1:0]           line_cnt_q, line_cnt_d;
  logic [BITS_TRANS-1:0]   num_trans_q, num_trans_d;
  logic                    wr_bank_q, wr_bank_d;
  logic [1:0]              bank_full_q, bank_full_d;
  logic                    err_q, err_d;

  logic                    line_valid;
  logic [LINE_BITS-1:0]    line_data;
  logic                    word_wr;
  logic                    asm_clr;
  logic [LW-1:0]           lines_seen;

  // Lines completed so far, counting a write that is being presented this cycle.
  assign lines_seen = line_cnt_q + LW'(line_valid);
  assign word_wr    = dma_vld && (state_q == ST_FILL) && (lines_seen < lines_q);
  assign asm_clr    = (state_q == ST_ISSUE);

  weight_line_assembler #(
    .AXI_WIDTH_DA (AXI_WIDTH_DA),
    .LINE_BITS    (LINE_BITS),
    .WPL          (WPL)
  ) u_line_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (asm_clr),
    .word_wr    (word_wr),
    .word       (dma_data),
    .line       (line_data),
    .line_valid (line_valid)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    lines_d     = lines_q;
    num_trans_d = num_trans_q;
    line_cnt_d  = line_cnt_q;
    wr_bank_d   = wr_bank_q;
    err_d       = err_q;
    bank_full_d = bank_full_q & ~bank_release;

    if (line_valid) begin
      line_cnt_d = line_cnt_q + LW'(1);
    end
    // Words beyond the last line of the tile are dropped.
    if (dma_vld && (state_q == ST_FILL) && !word_wr) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (tile_start) begin
          addr_d      = tile_addr;
          lines_d     = tile_lines;
          num_trans_d = BITS_TRANS'(tile_lines) * BITS_TRANS'(WPL);
          err_d       = 1'b0;
          state_d     = ST_WAIT_BANK;
        end
      end
      ST_WAIT_BANK: begin
        if (!bank_full_q[wr_bank_q] || bank_release[wr_bank_q]) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        line_cnt_d = '0;
        state_d    = ST_FILL;
      end
      ST_FILL: begin
        if (dma_done) begin
          if (lines_seen == lines_q) begin
            state_d = ST_FINISH;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_FINISH: begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
        state_d                = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      lines_q     <= '0;
      num_trans_q <= '0;
      line_cnt_q  <= '0;
      wr_bank_q   <= 1'b0;
      bank_full_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      lines_q     <= lines_d;
      num_trans_q <= num_trans_d;
      line_cnt_q  <= line_cnt_d;
      wr_bank_q   <= wr_bank_d;
      bank_full_q <= bank_full_d;
      err_q       <= err_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign dma_start     = (state_q == ST_ISSUE);
  assign load_done     = (state_q == ST_FINISH);
  assign dma_addr      = addr_q;
  assign dma_num_trans = num_trans_q;
  assign sram_we       = line_valid ? (wr_bank_q ? 2'b10 : 2'b01) : 2'b00;
  assign sram_addr     = line_cnt_q[SRAM_ADDRESS-1:0];
  assign sram_wdata    = line_data;
  assign bank_full     = bank_full_q;
  assign err           = err_q;

endmodule
